// File: rtl/step_distance_tracker_pkg.sv
// Shared constants, BCD digit type and BCD helper functions for the
// step/distance sensor counters. Imported by step_distance_tracker and its
// interface.
package fitbit_pkg;

  localparam int DEF_STEPS_PER_HALF = 2048;
  localparam int DEF_STEP_W         = 20;
  localparam int DEF_DIST_W         = 20;
  localparam int DEF_DIST_INC       = 5;
  localparam int DEF_BCD_DIGITS     = 6;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    logic       carry;
    bcd_digit_t digit;
  } bcd_sum_t;

  // Single BCD digit add: a + b + cin, with a decimal carry out.
  function automatic bcd_sum_t bcd_add_const(input bcd_digit_t a,
                                             input bcd_digit_t b,
                                             input logic cin);
    logic [4:0] s;
    bcd_sum_t   r;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (s > 5'd9) begin
      r.carry = 1'b1;
      r.digit = s[3:0] - 4'd10;
    end else begin
      r.carry = 1'b0;
      r.digit = s[3:0];
    end
    return r;
  endfunction

  // Decimal digit number idx (0 = units) of a constant; elaboration-time only.
  function automatic bcd_digit_t const_digit(input int value, input int idx);
    int v;
    v = value;
    for (int k = 0; k < idx; k++) begin
      v = v / 10;
    end
    return bcd_digit_t'(v % 10);
  endfunction

endpackage

// File: rtl/step_distance_tracker_if.sv
// Bus between the step/distance tracker and its consumer.
// Optional BCD readout is present only when DIST_BCD_EN is defined.
//
// Handshake: there is no valid/ready pair. X is a free-running raw level,
// run and clear are level controls sampled on every clk100MHz edge, and all
// outputs are registered and valid in every cycle after reset; half_tick is
// a single-cycle pulse that the consumer must sample every cycle.
interface step_distance_tracker_if
  import fitbit_pkg::*;
#(
  parameter int STEP_W = DEF_STEP_W,
  parameter int DIST_W = DEF_DIST_W
`ifdef DIST_BCD_EN
  , parameter int BCD_DIGITS = DEF_BCD_DIGITS
`endif
);

  logic              X;
  logic              run;
  logic              clear;
  logic [STEP_W-1:0] step_count;
  logic [DIST_W-1:0] distance_val;
  logic              half_tick;
  logic              overflow;
`ifdef DIST_BCD_EN
  logic [4*BCD_DIGITS-1:0] distance_bcd;
`endif

  // Sensor/controller side.
  modport master (
    output X, run, clear,
    input  step_count, distance_val, half_tick, overflow
`ifdef DIST_BCD_EN
    , input distance_bcd
`endif
  );

  // Tracker side.
  modport slave (
    input  X, run, clear,
    output step_count, distance_val, half_tick, overflow
`ifdef DIST_BCD_EN
    , output distance_bcd
`endif
  );

endinterface

// File: rtl/step_distance_tracker_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a raw sensor line.
// Reusable by any counter fed from an asynchronous pulse input.
module step_edge_sync (
  input  logic clk100MHz,
  input  logic reset,
  input  logic X,
  output logic step_edge
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  // Synchronise X and keep the previous synchronised sample for edge detection.
  always_ff @(posedge clk100MHz) begin
    if (!reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= X;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign step_edge = r_s2 & ~r_prev;

endmodule

// File: rtl/step_distance_tracker.sv
// Step counter and incremental distance accumulator.
// Counts rising edges of the raw step line while run is high, adds DIST_INC
// to the distance every STEPS_PER_HALF steps, saturates with a sticky
// overflow flag and pulses half_tick on every distance increment.
// Optional macro DIST_BCD_EN adds a packed-BCD copy of the distance kept by
// in-place decimal addition.
module step_distance_tracker
  import fitbit_pkg::*;
#(
  parameter int STEPS_PER_HALF = DEF_STEPS_PER_HALF,
  parameter int STEP_W         = DEF_STEP_W,
  parameter int DIST_W         = DEF_DIST_W,
  parameter int DIST_INC       = DEF_DIST_INC
`ifdef DIST_BCD_EN
  , parameter int BCD_DIGITS   = DEF_BCD_DIGITS
`endif
) (
  input logic                    clk100MHz,
  input logic                    reset,
  step_distance_tracker_if.slave bus
);

  localparam int                HALF_W       = $clog2(STEPS_PER_HALF);
  localparam logic [HALF_W-1:0] HALF_LAST    = HALF_W'(STEPS_PER_HALF - 1);
  localparam logic [DIST_W:0]   DIST_INC_EXT = (DIST_W + 1)'(DIST_INC);
  localparam logic [DIST_W:0]   DIST_CEIL    = {1'b0, {DIST_W{1'b1}}};
  localparam logic [STEP_W-1:0] STEP_CEIL    = {STEP_W{1'b1}};

  logic [STEP_W-1:0] r_step;
  logic [DIST_W-1:0] r_dist;
  logic [HALF_W-1:0] r_half;
  logic              r_half_tick;
  logic              r_overflow;

  logic              w_step_edge;
  logic              w_accept;
  logic              w_wrap;
  logic [STEP_W-1:0] w_step_next;
  logic              w_step_hits_ceil;
  logic [HALF_W-1:0] w_half_next;
  logic [DIST_W:0]   w_dist_sum;
  logic              w_dist_hits_ceil;
  logic [DIST_W-1:0] w_dist_next;
  logic              w_bcd_hits_ceil;
  logic              w_overflow_set;

  step_edge_sync u_edge_sync (
    .clk100MHz (clk100MHz),
    .reset     (reset),
    .X         (bus.X),
    .step_edge (w_step_edge)
  );

  // A step coinciding with clear is dropped; the edge tracker keeps running
  // regardless of run so resuming with X already high adds nothing.
  assign w_accept = w_step_edge & bus.run & ~bus.clear;
  assign w_wrap   = w_accept & (r_half == HALF_LAST);

  assign w_step_next      = (r_step == STEP_CEIL) ? r_step : r_step + 1'b1;
  assign w_step_hits_ceil = (w_step_next == STEP_CEIL);
  assign w_half_next      = (r_half == HALF_LAST) ? '0 : r_half + 1'b1;

  // One extra bit on the sum makes the saturation compare free of wrap-around.
  // Overflow is raised as soon as a counter sits at its ceiling, including
  // the case where the add lands exactly on all-ones.
  assign w_dist_sum       = {1'b0, r_dist} + DIST_INC_EXT;
  assign w_dist_hits_ceil = (w_dist_sum >= DIST_CEIL);
  assign w_dist_next      = w_dist_hits_ceil ? {DIST_W{1'b1}} : w_dist_sum[DIST_W-1:0];

  assign w_overflow_set = w_accept &
                          (w_step_hits_ceil | (w_wrap & (w_dist_hits_ceil | w_bcd_hits_ceil)));

  // Step, half-unit and distance counters with clear below reset in priority.
  always_ff @(posedge clk100MHz) begin
    if (!reset) begin
      r_step      <= '0;
      r_dist      <= '0;
      r_half      <= '0;
      r_half_tick <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (bus.clear) begin
      r_step      <= '0;
      r_dist      <= '0;
      r_half      <= '0;
      r_half_tick <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_half_tick <= w_wrap;
      r_overflow  <= r_overflow | w_overflow_set;
      if (w_accept) begin
        r_step <= w_step_next;
        r_half <= w_half_next;
      end
      if (w_wrap) begin
        r_dist <= w_dist_next;
      end
    end
  end

`ifdef DIST_BCD_EN
  localparam logic [4*BCD_DIGITS-1:0] BCD_NINES = {BCD_DIGITS{4'h9}};

  logic [4*BCD_DIGITS-1:0] r_bcd;
  logic [4*BCD_DIGITS-1:0] w_bcd_sum;
  logic [4*BCD_DIGITS-1:0] w_bcd_next;
  logic [BCD_DIGITS:0]     w_bcd_carry;

  assign w_bcd_carry[0] = 1'b0;

  // Ripple decimal add of the constant increment, digit by digit.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_bcd_digit
    localparam bcd_digit_t INC_DIGIT = const_digit(DIST_INC, g);
    bcd_sum_t w_digit_sum;
    assign w_digit_sum          = bcd_add_const(r_bcd[4*g +: 4], INC_DIGIT, w_bcd_carry[g]);
    assign w_bcd_sum[4*g +: 4]  = w_digit_sum.digit;
    assign w_bcd_carry[g+1]     = w_digit_sum.carry;
  end

  // BCD saturates on its own ceiling, independent of the binary distance.
  assign w_bcd_hits_ceil = w_bcd_carry[BCD_DIGITS] | (w_bcd_sum == BCD_NINES);
  assign w_bcd_next      = w_bcd_hits_ceil ? BCD_NINES : w_bcd_sum;

  // BCD distance follows the binary distance on every half-unit wrap.
  always_ff @(posedge clk100MHz) begin
    if (!reset) begin
      r_bcd <= '0;
    end else if (bus.clear) begin
      r_bcd <= '0;
    end else if (w_wrap) begin
      r_bcd <= w_bcd_next;
    end
  end

  assign bus.distance_bcd = r_bcd;
`else
  assign w_bcd_hits_ceil = 1'b0;
`endif

  assign bus.step_count   = r_step;
  assign bus.distance_val = r_dist;
  assign bus.half_tick    = r_half_tick;
  assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_step_distance_tracker.sv
// Bench for step_distance_tracker: a default-parameter instance, a small
// saturating instance (STEPS_PER_HALF=4, DIST_W=4) and, with DIST_BCD_EN,
// a BCD instance (STEPS_PER_HALF=2). Expected values come from a step-count
// model: distance = min((steps / STEPS_PER_HALF) * DIST_INC, ceiling).
module tb_step_distance_tracker;

  localparam int SPH_A  = 2048;
  localparam int INC_A  = 5;
  localparam int DW_A   = 20;
  localparam int SW     = 20;
  localparam int SPH_B  = 4;
  localparam int INC_B  = 5;
  localparam int DW_B   = 4;
  localparam int SPH_C  = 2;

  // ---------------- clock / reset ----------------
  logic clk100MHz = 1'b0;
  logic reset     = 1'b0;
  int   cyc       = 0;
  int   tests     = 0;
  int   fails     = 0;
  bit   started   = 1'b0;

  always #5 clk100MHz = ~clk100MHz;
  always @(posedge clk100MHz) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  step_distance_tracker_if #(.STEP_W(SW), .DIST_W(DW_A)) bus_a ();
  step_distance_tracker_if #(.STEP_W(SW), .DIST_W(DW_B)) bus_b ();

  step_distance_tracker #(.STEPS_PER_HALF(SPH_A), .STEP_W(SW), .DIST_W(DW_A), .DIST_INC(INC_A)) u_dut (
    .clk100MHz (clk100MHz),
    .reset     (reset),
    .bus       (bus_a)
  );

  step_distance_tracker #(.STEPS_PER_HALF(SPH_B), .STEP_W(SW), .DIST_W(DW_B), .DIST_INC(INC_B)) u_small (
    .clk100MHz (clk100MHz),
    .reset     (reset),
    .bus       (bus_b)
  );

`ifdef DIST_BCD_EN
  step_distance_tracker_if #(.STEP_W(SW), .DIST_W(DW_A)) bus_c ();
  step_distance_tracker #(.STEPS_PER_HALF(SPH_C), .STEP_W(SW), .DIST_W(DW_A), .DIST_INC(INC_A)) u_bcd (
    .clk100MHz (clk100MHz),
    .reset     (reset),
    .bus       (bus_c)
  );
  int acc_c = 0;
`endif

  // ---------------- reference model ----------------
  int acc_a = 0;
  int acc_b = 0;
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  function automatic longint m_step(input longint acc, input int w);
    longint mx;
    mx = (64'd1 << w) - 1;
    return (acc > mx) ? mx : acc;
  endfunction

  function automatic longint m_dist(input longint acc, input int sph, input int inc, input int w);
    longint mx, d;
    mx = (64'd1 << w) - 1;
    d  = (acc / sph) * inc;
    return (d > mx) ? mx : d;
  endfunction

  function automatic bit m_ovf(input longint acc, input int sph, input int inc, input int dw);
    longint dmx, smx;
    dmx = (64'd1 << dw) - 1;
    smx = (64'd1 << SW) - 1;
    return (acc >= smx) || ((acc / sph) * inc >= dmx);
  endfunction

  function automatic logic [23:0] m_bcd(input int v);
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // ---------------- half_tick scoreboard ----------------
  always @(negedge clk100MHz) begin
    if (started) begin
      if (exp_q_a.size() > 0 && exp_q_a[0] == cyc) begin
        void'(exp_q_a.pop_front());
        tests++;
        if (bus_a.half_tick !== 1'b1) begin
          fails++;
          $display("FAIL half_tick_a_missing cycle=%0d got=%b want=1", cyc, bus_a.half_tick);
        end
      end else if (bus_a.half_tick !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL half_tick_a_unexpected cycle=%0d got=%b want=0", cyc, bus_a.half_tick);
      end
      if (exp_q_b.size() > 0 && exp_q_b[0] == cyc) begin
        void'(exp_q_b.pop_front());
        tests++;
        if (bus_b.half_tick !== 1'b1) begin
          fails++;
          $display("FAIL half_tick_b_missing cycle=%0d got=%b want=1", cyc, bus_b.half_tick);
        end
      end else if (bus_b.half_tick !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL half_tick_b_unexpected cycle=%0d got=%b want=0", cyc, bus_b.half_tick);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk100MHz);
      #1;
    end
  endtask

  // One X pulse; returns at least 3 edges after the rise so the step has landed.
  task automatic pulse_a();
    int hi, lo;
    hi = $urandom_range(1, 2);
    lo = $urandom_range(2, 3);
    bus_a.X = 1'b1;
    if (bus_a.run && !bus_a.clear) begin
      acc_a++;
      if (acc_a % SPH_A == 0) exp_q_a.push_back(32'(cyc + 3));
    end
    step_clk(hi);
    bus_a.X = 1'b0;
    step_clk(lo);
  endtask

  task automatic pulse_b();
    int hi, lo;
    hi = $urandom_range(1, 2);
    lo = $urandom_range(2, 3);
    bus_b.X = 1'b1;
    acc_b++;
    if (acc_b % SPH_B == 0) exp_q_b.push_back(32'(cyc + 3));
    step_clk(hi);
    bus_b.X = 1'b0;
    step_clk(lo);
  endtask

  task automatic clear_a();
    bus_a.clear = 1'b1;
    step_clk(1);
    bus_a.clear = 1'b0;
    acc_a = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset   = 1'b0;
    bus_a.X = 1'($urandom_range(0, 1));
    bus_b.X = 1'($urandom_range(0, 1));
    step_clk(2);
    tests++;
    if (bus_a.step_count !== '0 || bus_a.distance_val !== '0 ||
        bus_a.half_tick !== 1'b0 || bus_a.overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_a got step=%0d dist=%0d tick=%b ovf=%b want all 0",
               bus_a.step_count, bus_a.distance_val, bus_a.half_tick, bus_a.overflow);
    end
    tests++;
    if (bus_b.step_count !== '0 || bus_b.distance_val !== '0 ||
        bus_b.half_tick !== 1'b0 || bus_b.overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_b got step=%0d dist=%0d tick=%b ovf=%b want all 0",
               bus_b.step_count, bus_b.distance_val, bus_b.half_tick, bus_b.overflow);
    end
    bus_a.X = 1'b0;
    bus_b.X = 1'b0;
    reset   = 1'b1;
    step_clk(2);
    started = 1'b1;
  endtask

  task automatic test_three_steps();
    for (int i = 0; i < 3; i++) begin
      pulse_a();
      tests++;
      if (bus_a.step_count !== SW'(m_step(acc_a, SW)) || bus_a.distance_val !== '0) begin
        fails++;
        $display("FAIL three_steps[%0d] got step=%0d dist=%0d want step=%0d dist=0",
                 i, bus_a.step_count, bus_a.distance_val, m_step(acc_a, SW));
      end
    end
  endtask

  task automatic test_half_unit();
    int targets[3] = '{2048, 4095, 4096};
    for (int t = 0; t < 3; t++) begin
      while (acc_a < targets[t]) pulse_a();
      tests++;
      if (bus_a.step_count !== SW'(m_step(acc_a, SW)) ||
          bus_a.distance_val !== DW_A'(m_dist(acc_a, SPH_A, INC_A, DW_A)) ||
          bus_a.overflow !== 1'b0) begin
        fails++;
        $display("FAIL half_unit[%0d] got step=%0d dist=%0d ovf=%b want step=%0d dist=%0d ovf=0",
                 targets[t], bus_a.step_count, bus_a.distance_val, bus_a.overflow,
                 m_step(acc_a, SW), m_dist(acc_a, SPH_A, INC_A, DW_A));
      end
    end
  endtask

  task automatic test_run_pause();
    bus_a.run = 1'b0;
    repeat (100) pulse_a();
    tests++;
    if (bus_a.step_count !== SW'(m_step(acc_a, SW))) begin
      fails++;
      $display("FAIL paused_steps got=%0d want=%0d", bus_a.step_count, m_step(acc_a, SW));
    end
    bus_a.X = 1'b1;
    step_clk(4);
    bus_a.run = 1'b1;
    step_clk(5);
    tests++;
    if (bus_a.step_count !== SW'(m_step(acc_a, SW))) begin
      fails++;
      $display("FAIL resume_high got=%0d want=%0d", bus_a.step_count, m_step(acc_a, SW));
    end
    bus_a.X = 1'b0;
    step_clk(2);
    pulse_a();
    tests++;
    if (bus_a.step_count !== SW'(m_step(acc_a, SW))) begin
      fails++;
      $display("FAIL resume_next_edge got=%0d want=%0d", bus_a.step_count, m_step(acc_a, SW));
    end
  endtask

  task automatic test_clear_collision();
    clear_a();
    tests++;
    if (bus_a.step_count !== '0 || bus_a.distance_val !== '0 || bus_a.overflow !== 1'b0) begin
      fails++;
      $display("FAIL clear got step=%0d dist=%0d ovf=%b want 0 0 0",
               bus_a.step_count, bus_a.distance_val, bus_a.overflow);
    end
    while (acc_a < SPH_A - 1) pulse_a();
    tests++;
    if (bus_a.step_count !== SW'(SPH_A - 1)) begin
      fails++;
      $display("FAIL pre_collision got=%0d want=%0d", bus_a.step_count, SPH_A - 1);
    end
    // Rise now; the step would land on the third edge, where clear is high.
    bus_a.X = 1'b1;
    step_clk(2);
    bus_a.clear = 1'b1;
    step_clk(1);
    bus_a.clear = 1'b0;
    acc_a = 0;
    step_clk(2);
    bus_a.X = 1'b0;
    step_clk(3);
    tests++;
    if (bus_a.step_count !== '0 || bus_a.distance_val !== '0 || bus_a.overflow !== 1'b0) begin
      fails++;
      $display("FAIL clear_collision got step=%0d dist=%0d ovf=%b want 0 0 0",
               bus_a.step_count, bus_a.distance_val, bus_a.overflow);
    end
    pulse_a();
    tests++;
    if (bus_a.step_count !== SW'(m_step(acc_a, SW))) begin
      fails++;
      $display("FAIL after_collision got=%0d want=%0d", bus_a.step_count, m_step(acc_a, SW));
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 16; i++) begin
      pulse_b();
      if (i % 4 == 0) begin
        tests++;
        if (bus_b.distance_val !== DW_B'(m_dist(acc_b, SPH_B, INC_B, DW_B)) ||
            bus_b.overflow !== m_ovf(acc_b, SPH_B, INC_B, DW_B) ||
            bus_b.step_count !== SW'(m_step(acc_b, SW))) begin
          fails++;
          $display("FAIL saturation[%0d] got dist=%0d ovf=%b step=%0d want dist=%0d ovf=%b step=%0d",
                   i, bus_b.distance_val, bus_b.overflow, bus_b.step_count,
                   m_dist(acc_b, SPH_B, INC_B, DW_B), m_ovf(acc_b, SPH_B, INC_B, DW_B),
                   m_step(acc_b, SW));
        end
      end
    end
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 150; i++) begin
      bus_a.run = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 19) == 0) clear_a();
      pulse_a();
      tests++;
      if (bus_a.step_count !== SW'(m_step(acc_a, SW)) ||
          bus_a.distance_val !== DW_A'(m_dist(acc_a, SPH_A, INC_A, DW_A)) ||
          bus_a.overflow !== m_ovf(acc_a, SPH_A, INC_A, DW_A)) begin
        fails++;
        $display("FAIL random_mix[%0d] got step=%0d dist=%0d ovf=%b want step=%0d dist=%0d ovf=%b",
                 i, bus_a.step_count, bus_a.distance_val, bus_a.overflow, m_step(acc_a, SW),
                 m_dist(acc_a, SPH_A, INC_A, DW_A), m_ovf(acc_a, SPH_A, INC_A, DW_A));
      end
    end
    bus_a.run = 1'b1;
  endtask

`ifdef DIST_BCD_EN
  task automatic test_bcd();
    int checkpoints[3] = '{4, 20, 40};
    for (int t = 0; t < 3; t++) begin
      while (acc_c < checkpoints[t]) begin
        bus_c.X = 1'b1;
        acc_c++;
        step_clk(1);
        bus_c.X = 1'b0;
        step_clk(2);
      end
      tests++;
      if (bus_c.distance_val !== DW_A'(m_dist(acc_c, SPH_C, INC_A, DW_A)) ||
          bus_c.distance_bcd !== m_bcd(int'(m_dist(acc_c, SPH_C, INC_A, DW_A)))) begin
        fails++;
        $display("FAIL bcd[%0d] got dist=%0d bcd=%h want dist=%0d bcd=%h",
                 acc_c, bus_c.distance_val, bus_c.distance_bcd,
                 m_dist(acc_c, SPH_C, INC_A, DW_A), m_bcd(int'(m_dist(acc_c, SPH_C, INC_A, DW_A))));
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    bus_a.X = 1'b0; bus_a.run = 1'b1; bus_a.clear = 1'b0;
    bus_b.X = 1'b0; bus_b.run = 1'b1; bus_b.clear = 1'b0;
`ifdef DIST_BCD_EN
    bus_c.X = 1'b0; bus_c.run = 1'b1; bus_c.clear = 1'b0;
`endif
    step_clk(1);
    test_reset();
    test_three_steps();
    test_half_unit();
    test_run_pause();
    test_clear_collision();
    test_saturation();
    test_random_mix();
`ifdef DIST_BCD_EN
    test_bcd();
`endif
    step_clk(4);
    tests++;
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
      fails++;
      $display("FAIL tick_queue_drain got pending_a=%0d pending_b=%0d want 0 0",
               exp_q_a.size(), exp_q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    fails++;
    $display("FAIL watchdog cycle=%0d limit reached", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
